// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers raster timing (pixel_x/pixel_y/video_active) from
// an incoming active-low hsync/vsync pair, measures line and frame periods and
// locks after LOCK_FRAMES consecutive frames that match the configured timing.
// Optional build macro VGA_DEC_SYNC_EN: inserts a two-flop synchronizer on each
// sync input ahead of the edge register (for asynchronous sources, +2 clocks).
module vga_sync_decoder #(
  parameter int H_D         = 640,
  parameter int H_FP        = 16,
  parameter int H_TOTAL     = 800,
  parameter int V_D         = 480,
  parameter int V_FP        = 10,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_active,
  output logic       frame_start,
  output logic       locked,
  output logic [9:0] h_period,
  output logic [9:0] v_period
);

  localparam logic [10:0] H_TOTAL_C  = 11'(H_TOTAL);
  localparam logic [10:0] H_TIMEOUT  = 11'(2 * H_TOTAL);
  localparam logic [10:0] H_TMO_LAST = 11'(2 * H_TOTAL - 1);
  localparam logic [10:0] H_SAT      = 11'd1023;
  localparam logic [9:0]  X_LOAD     = 10'(H_D + H_FP + 1);
  localparam logic [9:0]  X_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  X_VIS      = 10'(H_D);
  localparam logic [9:0]  Y_LOAD     = 10'(V_D + V_FP);
  localparam logic [9:0]  Y_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  Y_VIS      = 10'(V_D);
  localparam logic [9:0]  V_TOTAL_C  = 10'(V_TOTAL);
  localparam logic [9:0]  V_SAT      = 10'd1023;
  localparam logic [2:0]  LOCK_N     = 3'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t      state, state_n;
  logic        hs_stage, vs_stage;
  logic [1:0]  hs_edge, vs_edge;
  logic        h_fall, v_fall;
  logic [10:0] hcnt, hcnt_n;
  logic [9:0]  vcnt, vcnt_n;
  logic [9:0]  px_n, py_n, hp_n, vp_n;
  logic        line_bad, line_bad_n;
  logic [2:0]  good_cnt, good_n;
  logic        fs_n, h_bad, v_bad, timeout, locked_n, va_n;

`ifdef VGA_DEC_SYNC_EN
  logic [1:0] hs_sync, vs_sync;

  // Two-flop synchronizers; idle (high) level out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_sync <= 2'b11;
      vs_sync <= 2'b11;
    end else begin
      hs_sync <= {hs_sync[0], hsync_in};
      vs_sync <= {vs_sync[0], vsync_in};
    end
  end

  assign hs_stage = hs_sync[1];
  assign vs_stage = vs_sync[1];
`else
  assign hs_stage = hsync_in;
  assign vs_stage = vsync_in;
`endif

  // Edge register: [0] is the current sample, [1] the previous one; reset to
  // the idle level so a low sync at release is not mistaken for a fall.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_edge <= 2'b11;
      vs_edge <= 2'b11;
    end else begin
      hs_edge <= {hs_edge[0], hs_stage};
      vs_edge <= {vs_edge[0], vs_stage};
    end
  end

  assign h_fall = hs_edge[1] & ~hs_edge[0];
  assign v_fall = vs_edge[1] & ~vs_edge[0];

  // Next-state for counters, raster position and the lock FSM. Horizontal
  // processing comes first so a coincident vsync fall sees the updated vcnt.
  // NOTE: every signal gets a default at the top so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n    = state;
    hcnt_n     = hcnt;
    vcnt_n     = vcnt;
    px_n       = pixel_x;
    py_n       = pixel_y;
    hp_n       = h_period;
    vp_n       = v_period;
    line_bad_n = line_bad;
    good_n     = good_cnt;
    fs_n       = 1'b0;
    h_bad      = 1'b0;
    timeout    = 1'b0;

    if (h_fall) begin
      hp_n   = (hcnt > H_SAT) ? H_SAT[9:0] : hcnt[9:0];
      h_bad  = (hcnt != H_TOTAL_C);
      hcnt_n = 11'd1;
      px_n   = X_LOAD;
      vcnt_n = (vcnt == V_SAT) ? vcnt : vcnt + 10'd1;
    end else begin
      if (hcnt != H_TIMEOUT) hcnt_n = hcnt + 11'd1;
      timeout = (hcnt == H_TMO_LAST);
      if (pixel_x == X_LAST) begin
        px_n = 10'd0;
        py_n = (pixel_y == Y_LAST) ? 10'd0 : pixel_y + 10'd1;
      end else begin
        px_n = pixel_x + 10'd1;
      end
    end

    v_bad = (vcnt_n != V_TOTAL_C);
    if (v_fall) begin
      vp_n   = vcnt_n;
      vcnt_n = 10'd0;
      py_n   = Y_LOAD;
      fs_n   = 1'b1;
    end

    // The first hsync fall after SEARCH entry only starts a measurement:
    // line_bad is held clear in SEARCH and LOCKED never sees a first fall.
    unique case (state)
      SEARCH: begin
        if (v_fall) state_n = MEASURE;
      end
      MEASURE: begin
        if (h_bad) line_bad_n = 1'b1;
        if (v_fall) begin
          if (!v_bad && !line_bad_n) begin
            good_n = good_cnt + 3'd1;
            if (good_n == LOCK_N) state_n = LOCKED;
          end else begin
            good_n = 3'd0;
          end
          line_bad_n = 1'b0;
        end
      end
      LOCKED: begin
        if (h_bad || (v_fall && v_bad)) state_n = SEARCH;
      end
      default: state_n = SEARCH;
    endcase

    if (timeout) state_n = SEARCH;
    if (state_n == SEARCH) begin
      good_n     = 3'd0;
      line_bad_n = 1'b0;
    end

    locked_n = (state_n == LOCKED);
    va_n     = locked_n && (px_n < X_VIS) && (py_n < Y_VIS);
  end

  // Lock FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= SEARCH;
    else       state <= state_n;
  end

  // Counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt         <= '0;
      vcnt         <= '0;
      pixel_x      <= '0;
      pixel_y      <= '0;
      h_period     <= '0;
      v_period     <= '0;
      line_bad     <= 1'b0;
      good_cnt     <= '0;
      frame_start  <= 1'b0;
      locked       <= 1'b0;
      video_active <= 1'b0;
    end else begin
      hcnt         <= hcnt_n;
      vcnt         <= vcnt_n;
      pixel_x      <= px_n;
      pixel_y      <= py_n;
      h_period     <= hp_n;
      v_period     <= vp_n;
      line_bad     <= line_bad_n;
      good_cnt     <= good_n;
      frame_start  <= fs_n;
      locked       <= locked_n;
      video_active <= va_n;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: directed bench for vga_sync_decoder. A reduced raster
// (512 clocks x 10 lines) keeps frames short; H_TOTAL stays at 512 so the
// 2*H_TOTAL timeout still drives h_period into its 1023 saturation.
// Source raster: hsync low for x in [416,464); vsync changes at x=416 and is
// low on lines 6 and 7, so vsync falls together with the line-6 hsync fall.
// The source is driven on the falling clock edge (plus 2 ns extra skew when
// VGA_DEC_SYNC_EN is defined); recovered pixel_x then trails the last driven
// source column by 1 clock, plus 2 with the synchronizer.
module tb_vga_sync_decoder;

  localparam int H_D      = 400;
  localparam int H_FP     = 16;
  localparam int H_TOTAL  = 512;
  localparam int V_D      = 4;
  localparam int V_FP     = 2;
  localparam int V_TOTAL  = 10;
  localparam int HS_START = H_D + H_FP;
  localparam int HS_END   = HS_START + 48;
  localparam int VS_LINE  = V_D + V_FP;
`ifdef VGA_DEC_SYNC_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif
  localparam int LAG = 1 + EXTRA;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hsync_in = 1'b1;
  logic       vsync_in = 1'b1;
  logic [9:0] pixel_x, pixel_y, h_period, v_period;
  logic       video_active, frame_start, locked;

  int   sx = 0, sy = 0, last_x = 0, last_y = 0;
  int   cur_len = H_TOTAL, frame_lines = V_TOTAL;
  bit   hold_h = 1'b0;
  logic vs_lvl = 1'b1;
  int   passed = 0, total = 0;

  vga_sync_decoder #(
    .H_D(H_D), .H_FP(H_FP), .H_TOTAL(H_TOTAL),
    .V_D(V_D), .V_FP(V_FP), .V_TOTAL(V_TOTAL), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .video_active(video_active),
    .frame_start(frame_start), .locked(locked),
    .h_period(h_period), .v_period(v_period)
  );

  always #5 clk = ~clk;

  // Drive one source pixel; outputs read after return reflect the last posedge.
  task automatic step();
    @(negedge clk);
`ifdef VGA_DEC_SYNC_EN
    #2;
`endif
    last_x   = sx;
    last_y   = sy;
    hsync_in = hold_h ? 1'b1 : !(sx >= HS_START && sx < HS_END);
    if (sx == HS_START) vs_lvl = !(sy == VS_LINE || sy == VS_LINE + 1);
    vsync_in = vs_lvl;
    if (sx >= cur_len - 1) begin
      sx      = 0;
      cur_len = H_TOTAL;
      if (sy >= frame_lines - 1) begin
        sy          = 0;
        frame_lines = V_TOTAL;
      end else begin
        sy++;
      end
    end else begin
      sx++;
    end
  endtask

  // Advance until source pixel (y,x) has just been driven, bounded.
  task automatic run_to(input int y, input int x, input string tag);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(last_y == y && last_x == x) && n < 12000);
    if (!(last_y == y && last_x == x)) begin
      total++;
      $display("FAIL %s: source (%0d,%0d) not reached, at (%0d,%0d)", tag, y, x, last_y, last_x);
    end
  endtask

  task automatic test_reset();
    repeat (5) step();
    reset = 1'b0;
    run_to(8, 500, "rst_pre");
    total++;
    if (h_period !== 10'd512) $display("FAIL pre_rst_h_period: got %0d expected 512", h_period);
    else passed++;
    reset = 1'b1;
    repeat (5) step();
    total++; if (pixel_x !== 10'd0) $display("FAIL rst_pixel_x: got %0d expected 0", pixel_x); else passed++;
    total++; if (pixel_y !== 10'd0) $display("FAIL rst_pixel_y: got %0d expected 0", pixel_y); else passed++;
    total++; if (video_active !== 1'b0) $display("FAIL rst_video_active: got %b expected 0", video_active); else passed++;
    total++; if (frame_start !== 1'b0) $display("FAIL rst_frame_start: got %b expected 0", frame_start); else passed++;
    total++; if (locked !== 1'b0) $display("FAIL rst_locked: got %b expected 0", locked); else passed++;
    total++; if (h_period !== 10'd0) $display("FAIL rst_h_period: got %0d expected 0", h_period); else passed++;
    total++; if (v_period !== 10'd0) $display("FAIL rst_v_period: got %0d expected 0", v_period); else passed++;
    reset = 1'b0;
  endtask

  // Released in SEARCH: 1st vsync fall starts MEASURE, 2nd and 3rd are good.
  task automatic test_lock();
    int   n = 0, fs = 0;
    logic prev_locked = 1'b0, lock_at2 = 1'bx, lock_at3 = 1'bx, before3 = 1'bx;
    bit   early = 1'b0;
    while (fs < 3 && n < 20000) begin
      prev_locked = locked;
      step();
      n++;
      if (frame_start === 1'b1) begin
        fs++;
        if (fs == 2) lock_at2 = locked;
        if (fs == 3) begin
          lock_at3 = locked;
          before3  = prev_locked;
        end
      end else if (locked === 1'b1) begin
        early = 1'b1;
      end
    end
    total++; if (fs != 3) $display("FAIL lock_frames: saw %0d frame_start pulses expected 3", fs); else passed++;
    total++; if (early !== 1'b0) $display("FAIL lock_early: locked rose outside a frame_start cycle"); else passed++;
    total++; if (lock_at2 !== 1'b0) $display("FAIL lock_at_2nd: got %b expected 0", lock_at2); else passed++;
    total++; if (lock_at3 !== 1'b1) $display("FAIL lock_at_3rd: got %b expected 1", lock_at3); else passed++;
    total++; if (before3 !== 1'b0) $display("FAIL lock_before_3rd: got %b expected 0", before3); else passed++;
    step();
    total++; if (frame_start !== 1'b0) $display("FAIL frame_start_width: got %b expected 0", frame_start); else passed++;
  endtask

  task automatic test_active();
    run_to(0, LAG, "first_visible");
    total++; if (pixel_x !== 10'd0) $display("FAIL vis_pixel_x: got %0d expected 0", pixel_x); else passed++;
    total++; if (pixel_y !== 10'd0) $display("FAIL vis_pixel_y: got %0d expected 0", pixel_y); else passed++;
    total++; if (video_active !== 1'b1) $display("FAIL vis_active: got %b expected 1", video_active); else passed++;
    total++; if (h_period !== 10'd512) $display("FAIL vis_h_period: got %0d expected 512", h_period); else passed++;
    total++; if (v_period !== 10'd10) $display("FAIL vis_v_period: got %0d expected 10", v_period); else passed++;
    run_to(0, H_D - 1 + LAG, "last_visible");
    total++; if (pixel_x !== 10'd399 || video_active !== 1'b1)
      $display("FAIL last_col: got x=%0d act=%b expected x=399 act=1", pixel_x, video_active); else passed++;
    step();
    total++; if (pixel_x !== 10'd400 || video_active !== 1'b0)
      $display("FAIL h_blank: got x=%0d act=%b expected x=400 act=0", pixel_x, video_active); else passed++;
    run_to(3, LAG, "last_row");
    total++; if (pixel_y !== 10'd3 || video_active !== 1'b1)
      $display("FAIL last_row: got y=%0d act=%b expected y=3 act=1", pixel_y, video_active); else passed++;
    run_to(4, LAG, "v_blank");
    total++; if (pixel_y !== 10'd4 || pixel_x !== 10'd0 || video_active !== 1'b0)
      $display("FAIL v_blank: got y=%0d x=%0d act=%b expected y=4 x=0 act=0", pixel_y, pixel_x, video_active); else passed++;
  endtask

  // Line 4 lasts 513 clocks; the line-5 hsync fall must unlock.
  task automatic test_stretch();
    int   n = 0;
    logic prev_locked = 1'b1;
    cur_len = H_TOTAL + 1;
    while (h_period === 10'd512 && n < 2000) begin
      prev_locked = locked;
      step();
      n++;
    end
    total++; if (h_period !== 10'd513) $display("FAIL stretch_h_period: got %0d expected 513", h_period); else passed++;
    total++; if (locked !== 1'b0) $display("FAIL stretch_unlock: got %b expected 0", locked); else passed++;
    total++; if (prev_locked !== 1'b1) $display("FAIL stretch_prev_locked: got %b expected 1", prev_locked); else passed++;
  endtask

  // From SEARCH: MEASURE start, a 9-line frame, then two good frames.
  task automatic test_short_frame();
    int   n = 0, fs = 0;
    logic lock2 = 1'bx, lock3 = 1'bx, lock4 = 1'bx;
    logic [9:0] vp2 = 'x, vp3 = 'x;
    while (fs < 4 && n < 25000) begin
      step();
      n++;
      if (frame_start === 1'b1) begin
        fs++;
        if (fs == 1) frame_lines = V_TOTAL - 1;
        if (fs == 2) begin lock2 = locked; vp2 = v_period; end
        if (fs == 3) begin lock3 = locked; vp3 = v_period; end
        if (fs == 4) lock4 = locked;
      end
    end
    total++; if (fs != 4) $display("FAIL short_frames: saw %0d frame_start pulses expected 4", fs); else passed++;
    total++; if (vp2 !== 10'd9) $display("FAIL short_v_period: got %0d expected 9", vp2); else passed++;
    total++; if (lock2 !== 1'b0) $display("FAIL short_lock2: got %b expected 0", lock2); else passed++;
    total++; if (lock3 !== 1'b0) $display("FAIL short_lock3: got %b expected 0", lock3); else passed++;
    total++; if (vp3 !== 10'd10) $display("FAIL short_v_period3: got %0d expected 10", vp3); else passed++;
    total++; if (lock4 !== 1'b1) $display("FAIL short_relock: got %b expected 1", lock4); else passed++;
  endtask

  // hsync held high right after a line start (hcnt=1): timeout 1023 clocks later.
  task automatic test_timeout();
    int n = 0;
    run_to(0, HS_START + 2 + EXTRA, "tmo_start");
    total++; if (pixel_x !== 10'(HS_START + 1)) $display("FAIL tmo_align: got %0d expected %0d", pixel_x, HS_START + 1); else passed++;
    hold_h = 1'b1;
    while (locked === 1'b1 && n < 3000) begin
      step();
      n++;
    end
    total++; if (n != 1023) $display("FAIL timeout_clocks: got %0d expected 1023", n); else passed++;
    hold_h = 1'b0;
    n = 0;
    while (h_period === 10'd512 && n < 2000) begin
      step();
      n++;
    end
    total++; if (h_period !== 10'd1023) $display("FAIL timeout_h_period: got %0d expected 1023", h_period); else passed++;
    total++; if (locked !== 1'b0) $display("FAIL timeout_locked: got %b expected 0", locked); else passed++;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_active();
    test_stretch();
    test_short_frame();
    test_timeout();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
